// File: rtl/constraint_checker_seq.sv
// constraint_checker_seq: table-programmed sequential constraint checker.
// One candidate sample is latched, then one table entry is evaluated per clock.
// The result (pass / lowest failing index) is held until the sink accepts it,
// at which point the saturating pass/fail statistics counters advance.
// Optional build macro: CCHK_EARLY_EXIT_EN -- stop evaluating at the first
// failing entry (latency fail_idx+1); when undefined every entry is evaluated.
module constraint_checker_seq #(
    parameter int unsigned NUM_VARS = 20,
    parameter int unsigned VAR_W    = 32,
    parameter int unsigned NUM_CONS = 20,
    localparam int unsigned IDX_W   = $clog2(NUM_VARS),
    localparam int unsigned CID_W   = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1,
    localparam int unsigned CFG_W   = 6 + 2 * IDX_W + VAR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [CID_W-1:0]          cfg_addr,
    input  logic [CFG_W-1:0]          cfg_wdata,
    output logic                      cfg_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VARS*VAR_W-1:0] in_vars,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_pass,
    output logic [CID_W-1:0]          out_fail_idx,
    output logic [31:0]               pass_cnt,
    output logic [31:0]               fail_cnt
);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    // Field positions inside cfg_wdata: {en, inv, use_k, op[2:0], idx_a, idx_b, k}
    localparam int unsigned EnBit   = CFG_W - 1;
    localparam int unsigned InvBit  = CFG_W - 2;
    localparam int unsigned UseKBit = CFG_W - 3;
    localparam int unsigned OpLsb   = CFG_W - 6;
    localparam int unsigned IdxALsb = VAR_W + IDX_W;
    localparam int unsigned IdxBLsb = VAR_W;

    // Constraint table
    logic             tbl_en    [NUM_CONS];
    logic             tbl_inv   [NUM_CONS];
    logic             tbl_use_k [NUM_CONS];
    logic [2:0]       tbl_op    [NUM_CONS];
    logic [IDX_W-1:0] tbl_idx_a [NUM_CONS];
    logic [IDX_W-1:0] tbl_idx_b [NUM_CONS];
    logic [VAR_W-1:0] tbl_k     [NUM_CONS];

    logic [VAR_W-1:0] vars_q [NUM_VARS];

    state_e           state_q;
    logic [CID_W-1:0] cnt_q;
    logic             fail_seen_q;
    logic [CID_W-1:0] fail_idx_q;

    logic             cfg_ok;
    logic             accept;
    logic             last_entry;
    logic             early_stop;
    logic [VAR_W-1:0] op_a;
    logic [VAR_W-1:0] op_b;
    logic [VAR_W-1:0] sum;
    logic [VAR_W-1:0] diff;
    logic [VAR_W-1:0] shl;
    logic             f;
    logic             r;
    logic             pass_final;
    logic [CID_W-1:0] idx_final;

    // Writes are accepted only while idle and for an in-range address
    assign cfg_ok     = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < NUM_CONS);
    assign accept     = in_valid && in_ready;
    assign last_entry = (cnt_q == CID_W'(NUM_CONS - 1));

    // Enable bit is the only table state that needs a reset value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CONS); i++) begin
                tbl_en[i] <= 1'b0;
            end
        end else if (cfg_ok) begin
            tbl_en[cfg_addr] <= cfg_wdata[EnBit];
        end
    end

    // Remaining table fields are don't-care while the entry is disabled
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            tbl_inv[cfg_addr]   <= cfg_wdata[InvBit];
            tbl_use_k[cfg_addr] <= cfg_wdata[UseKBit];
            tbl_op[cfg_addr]    <= cfg_wdata[OpLsb +: 3];
            tbl_idx_a[cfg_addr] <= cfg_wdata[IdxALsb +: IDX_W];
            tbl_idx_b[cfg_addr] <= cfg_wdata[IdxBLsb +: IDX_W];
            tbl_k[cfg_addr]     <= cfg_wdata[VAR_W-1:0];
        end
    end

    // Latch the candidate sample on acceptance so the source may move on
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(NUM_VARS); i++) begin
                vars_q[i] <= in_vars[i*VAR_W +: VAR_W];
            end
        end
    end

    // Evaluate the table entry addressed by the current step counter
    always_comb begin
        op_a = (32'(tbl_idx_a[cnt_q]) < NUM_VARS) ? vars_q[tbl_idx_a[cnt_q]] : '0;
        if (tbl_use_k[cnt_q]) begin
            op_b = tbl_k[cnt_q];
        end else begin
            op_b = (32'(tbl_idx_b[cnt_q]) < NUM_VARS) ? vars_q[tbl_idx_b[cnt_q]] : '0;
        end
        sum  = op_a + op_b;
        diff = op_a - op_b;
        shl  = op_a << op_b[4:0];
        f    = 1'b0;
        case (tbl_op[cnt_q])
            3'd0:    f = |sum;
            3'd1:    f = |diff;
            3'd2:    f = |(op_a | op_b);
            3'd3:    f = |(op_a ^ op_b);
            3'd4:    f = (op_a != op_b);
            3'd5:    f = !((|op_a) && (|op_b));
            3'd6:    f = |shl;
            default: f = (|op_a) || (|op_b);
        endcase
        r          = !tbl_en[cnt_q] || (f ^ tbl_inv[cnt_q]);
        // Fold in the entry being evaluated this cycle
        pass_final = !fail_seen_q && r;
        idx_final  = fail_seen_q ? fail_idx_q : cnt_q;
    end

`ifdef CCHK_EARLY_EXIT_EN
    assign early_stop = !r;
`else
    assign early_stop = 1'b0;
`endif

    // Main FSM with registered handshake outputs, result and statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fail_seen_q  <= 1'b0;
            fail_idx_q   <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_pass     <= 1'b0;
            out_fail_idx <= '0;
            cfg_err      <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StEval;
                        cnt_q       <= '0;
                        fail_seen_q <= 1'b0;
                        fail_idx_q  <= '0;
                        in_ready    <= 1'b0;
                    end
                end
                StEval: begin
                    // Only the first failure is recorded
                    if (!r && !fail_seen_q) begin
                        fail_seen_q <= 1'b1;
                        fail_idx_q  <= cnt_q;
                    end
                    if (last_entry || early_stop) begin
                        state_q      <= StDone;
                        out_valid    <= 1'b1;
                        out_pass     <= pass_final;
                        out_fail_idx <= pass_final ? '0 : idx_final;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        if (out_pass) begin
                            pass_cnt <= (pass_cnt == '1) ? pass_cnt : pass_cnt + 1'b1;
                        end else begin
                            fail_cnt <= (fail_cnt == '1) ? fail_cnt : fail_cnt + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_constraint_checker_seq.sv
// Scoreboard bench for constraint_checker_seq: directed samples push expected
// (pass, fail index, latency) records; an independent monitor pops and checks
// each result as the DUT presents it.
module tb_constraint_checker_seq;

    localparam int NUM_VARS = 20;
    localparam int VAR_W    = 32;
    localparam int NUM_CONS = 20;
    localparam int CID_W    = 5;
    localparam int CFG_W    = 48;

    typedef logic [NUM_VARS*VAR_W-1:0] vec_t;
    typedef struct {
        bit pass;
        int idx;
        int lat;
        int acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [CID_W-1:0] cfg_addr;
    logic [CFG_W-1:0] cfg_wdata;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    vec_t             in_vars;
    logic             out_valid;
    logic             out_ready;
    logic             out_pass;
    logic [CID_W-1:0] out_fail_idx;
    logic [31:0]      pass_cnt;
    logic [31:0]      fail_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   exp_p = 0;
    int   exp_f = 0;
    exp_t sb[$];

    constraint_checker_seq #(
        .NUM_VARS(NUM_VARS),
        .VAR_W   (VAR_W),
        .NUM_CONS(NUM_CONS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vars     (in_vars),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pass    (out_pass),
        .out_fail_idx(out_fail_idx),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk(input bit en, input bit inv, input bit uk,
                                            input logic [2:0] op, input logic [4:0] ia,
                                            input logic [4:0] ib, input logic [31:0] k);
        return {en, inv, uk, op, ia, ib, k};
    endfunction

    function automatic vec_t vset(input vec_t v, input int i, input logic [31:0] x);
        vec_t t;
        t = v;
        t[i*VAR_W +: VAR_W] = x;
        return t;
    endfunction

    // Monitor: check each presented result once against the oldest expectation
    initial begin
        bit   seen;
        exp_t e;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid && !seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("out_pass", 64'(out_pass), 64'(e.pass));
                    chk("out_fail_idx", 64'(out_fail_idx), 64'(e.idx));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end else if (!out_valid) begin
                seen = 0;
            end
        end
    end

    function automatic int exp_lat(input bit p, input int idx);
`ifdef CCHK_EARLY_EXIT_EN
        return p ? NUM_CONS : idx + 1;
`else
        return NUM_CONS;
`endif
    endfunction

    task automatic push_exp(input bit p, input int idx);
        exp_t e;
        e.pass = p;
        e.idx  = p ? 0 : idx;
        e.lat  = exp_lat(p, idx);
        e.acc  = cyc;
        sb.push_back(e);
        if (p) exp_p++;
        else exp_f++;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input vec_t v, input bit p, input int idx);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
        in_vars  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        push_exp(p, idx);
        in_valid = 1'b0;
        in_vars  = {NUM_VARS{32'($urandom())}};
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("done_timeout", 64'(sb.size()), 64'(0));
        chk("pass_cnt", 64'(pass_cnt), 64'(exp_p));
        chk("fail_cnt", 64'(fail_cnt), 64'(exp_f));
    endtask

    task automatic cfg_write(input int addr, input logic [CFG_W-1:0] d, input bit exp_err);
        cfg_we    = 1'b1;
        cfg_addr  = CID_W'(addr);
        cfg_wdata = d;
        @(posedge clk);
        #1;
        chk("cfg_err", 64'(cfg_err), 64'(exp_err));
        cfg_we = 1'b0;
        @(posedge clk);
        #1;
        chk("cfg_err_pulse", 64'(cfg_err), 64'(0));
        @(negedge clk);
    endtask

    task automatic run_one(input vec_t v, input bit p, input int idx);
        send(v, p, idx);
        wait_done();
    endtask

    initial begin
        vec_t v;
        vec_t v5;
        int   n;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        in_valid  = 1'b0;
        in_vars   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_pass", 64'(out_pass), 64'(0));
        chk("rst_out_fail_idx", 64'(out_fail_idx), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        chk("rst_pass_cnt", 64'(pass_cnt), 64'(0));
        chk("rst_fail_cnt", 64'(fail_cnt), 64'(0));

        // Empty table passes everything
        run_one('0, 1, 0);

        // Entry 3: var17 != k
        cfg_write(3, mk(1, 0, 1, 3'd4, 5'd17, 5'd0, 32'h006f_6235), 0);
        run_one(vset('0, 17, 32'h006f_6235), 0, 3);
        run_one(vset('0, 17, 32'h1), 1, 0);

        // Multiple failures: lowest index wins
        cfg_write(2, mk(1, 0, 1, 3'd7, 5'd4, 5'd0, 32'h0), 0);
        cfg_write(5, mk(1, 0, 0, 3'd2, 5'd0, 5'd1, 32'h0), 0);
        run_one(vset('0, 17, 32'h006f_6235), 0, 2);
        run_one(vset('0, 4, 32'h1), 0, 5);

        // Wrap-around add, inversion, out-of-range index, shift, sub, nand
        cfg_write(2, '0, 0);
        cfg_write(3, '0, 0);
        cfg_write(5, '0, 0);
        cfg_write(0, mk(1, 0, 1, 3'd0, 5'd6, 5'd0, 32'h1), 0);
        run_one(vset('0, 6, 32'hFFFF_FFFF), 0, 0);
        cfg_write(0, mk(1, 1, 1, 3'd0, 5'd6, 5'd0, 32'h1), 0);
        run_one(vset('0, 6, 32'hFFFF_FFFF), 1, 0);
        run_one(vset('0, 6, 32'h5), 0, 0);
        cfg_write(0, '0, 0);
        cfg_write(1, mk(1, 0, 0, 3'd3, 5'd25, 5'd6, 32'h0), 0);
        run_one('0, 0, 1);
        run_one(vset('0, 6, 32'h7), 1, 0);
        cfg_write(1, '0, 0);
        cfg_write(19, mk(1, 0, 1, 3'd6, 5'd8, 5'd0, 32'h4), 0);
        run_one(vset('0, 8, 32'h1000_0000), 0, 19);
        run_one(vset('0, 8, 32'h0100_0000), 1, 0);
        cfg_write(10, mk(1, 0, 0, 3'd1, 5'd9, 5'd10, 32'h0), 0);
        cfg_write(11, mk(1, 0, 0, 3'd5, 5'd11, 5'd12, 32'h0), 0);
        v = vset('0, 8, 32'h0100_0000);
        v = vset(v, 9, 32'h55);
        v = vset(v, 10, 32'h55);
        run_one(v, 0, 10);
        v5 = vset(v, 10, 32'h56);
        v5 = vset(v5, 11, 32'h3);
        run_one(v5, 1, 0);
        run_one(vset(v5, 12, 32'h9), 0, 11);

        // Writes while busy or out of range are dropped
        send(v5, 1, 0);
        cfg_write(0, mk(1, 0, 0, 3'd4, 5'd0, 5'd0, 32'h0), 1);
        wait_done();
        run_one(v5, 1, 0);
        cfg_write(NUM_CONS, mk(1, 0, 0, 3'd4, 5'd0, 5'd0, 32'h0), 1);
        run_one(v5, 1, 0);

        // Write and accept on the same edge: the sample sees the new entry
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_wdata = mk(1, 0, 0, 3'd4, 5'd0, 5'd0, 32'h0);
        in_vars   = v5;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        push_exp(0, 0);
        chk("cfg_err_same_edge", 64'(cfg_err), 64'(0));
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        wait_done();
        cfg_write(0, '0, 0);

        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        send(v5, 1, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_out_valid_seen", 64'(out_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_out_pass", 64'(out_pass), 64'(1));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_pass_cnt", 64'(pass_cnt), 64'(exp_p - 1));
        end
        out_ready = 1'b1;
        wait_done();

        // Reset in the middle of an evaluation aborts it and clears state
        send(vset(v5, 8, 32'h0), 0, 19);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        exp_p = 0;
        exp_f = 0;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_pass_cnt", 64'(pass_cnt), 64'(0));
        chk("midrst_fail_cnt", 64'(fail_cnt), 64'(0));
        repeat (NUM_CONS + 2) begin
            @(negedge clk);
            chk("midrst_no_output", 64'(out_valid), 64'(0));
        end
        // Table cleared by reset: the formerly failing sample now passes
        run_one(vset(v5, 8, 32'h0), 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
